// File: rtl/fifo_sync_arb_pkg.sv
// rtl/fifo_sync_arb_pkg.sv - shared width helpers for the multi-channel packet FIFO
package fifo_sync_arb_pkg;

  // Pointer carries one extra MSB so full and empty stay distinguishable at equal indices.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-channel single-clock FIFO with occupancy-derived status
module fifo_sync
  import fifo_sync_arb_pkg::*;
#(
  parameter int DW        = 104,
  parameter int DEPTH     = 32,
  parameter int PROG_FULL = DEPTH / 2,
  localparam int PW       = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          prog_full
);

  localparam int AW = PW - 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  // Status is a pure function of the pointer registers: no input reaches it combinationally.
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign prog_full = (count >= PW'(PROG_FULL));

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Show-ahead head so the arbiter can load the output register in the grant cycle.
  assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fifo_sync_arb.sv
// rtl/fifo_sync_arb.sv - N per-channel FIFOs merged onto one output port by round-robin arbitration
module fifo_sync_arb
  import fifo_sync_arb_pkg::*;
#(
  parameter int DW        = 104,
  parameter int DEPTH     = 32,
  parameter int N         = 4,
  parameter int PROG_FULL = DEPTH / 2,
  localparam int CW       = chan_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    access_in,
  input  logic [N*DW-1:0] packet_in,
  output logic [N-1:0]    wait_out,
  output logic            access_out,
  output logic [DW-1:0]   packet_out,
  output logic [CW-1:0]   chan_out,
  input  logic            wait_in,
  output logic [N-1:0]    prog_full,
  output logic [N-1:0]    full,
  output logic [N-1:0]    empty,
  output logic [N-1:0]    overflow
);

  localparam int PW = ptr_width(DEPTH);

  logic [DW-1:0] head [N];
  logic [PW-1:0] count [N];
  logic [N-1:0]  pop;
  logic [N-1:0]  drop;
  logic [CW-1:0] last_grant;
  logic          load;
  logic          gnt_valid;
  logic [CW-1:0] gnt_idx;

  for (genvar i = 0; i < N; i++) begin : g_chan
    fifo_sync #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .PROG_FULL(PROG_FULL)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (access_in[i]),
      .din      (packet_in[i*DW +: DW]),
      .rd_en    (pop[i]),
      .dout     (head[i]),
      .count    (count[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .prog_full(prog_full[i])
    );

    // A full channel refuses the write even if it is popped in the same cycle.
    assign drop[i] = access_in[i] & (count[i] == PW'(DEPTH));
    assign pop[i]  = load & gnt_valid & (gnt_idx == CW'(i));
  end

  assign wait_out = prog_full;
  assign load     = ~access_out | ~wait_in;

  // Search starts one past the previous winner and wraps modulo N.
  always_comb begin
    int c;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_grant) + k) % N;
      if (!gnt_valid && !empty[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CW'(c);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      access_out <= 1'b0;
      packet_out <= '0;
      chan_out   <= '0;
      last_grant <= CW'(N - 1);
      overflow   <= '0;
    end else begin
      overflow <= overflow | drop;
      if (load) begin
        access_out <= gnt_valid;
        if (gnt_valid) begin
          packet_out <= head[gnt_idx];
          chan_out   <= gnt_idx;
          last_grant <= gnt_idx;
        end
      end
    end
  end

endmodule
